// File: rtl/id_stage_pipe_pkg.sv
// Shared MIPS opcode/funct constants and immediate-extension classification for the ID stage.
package id_stage_pipe_pkg;

    localparam logic [5:0] R_FORM = 6'h00;
    localparam logic [5:0] JAL    = 6'h03;
    localparam logic [5:0] BEQ    = 6'h04;
    localparam logic [5:0] BNE    = 6'h05;
    localparam logic [5:0] ADDI   = 6'h08;
    localparam logic [5:0] ADDIU  = 6'h09;
    localparam logic [5:0] SLTI   = 6'h0A;
    localparam logic [5:0] SLTIU  = 6'h0B;
    localparam logic [5:0] ANDI   = 6'h0C;
    localparam logic [5:0] ORI    = 6'h0D;
    localparam logic [5:0] XORI   = 6'h0E;
    localparam logic [5:0] LUI    = 6'h0F;
    localparam logic [5:0] LW     = 6'h23;
    localparam logic [5:0] SW     = 6'h2B;

    localparam logic [5:0] JR     = 6'h08;
    localparam logic [5:0] JALR   = 6'h09;
    localparam logic [5:0] MTHI   = 6'h11;
    localparam logic [5:0] MTLO   = 6'h13;
    localparam logic [5:0] MULT   = 6'h18;
    localparam logic [5:0] MULTU  = 6'h19;
    localparam logic [5:0] DIV    = 6'h1A;
    localparam logic [5:0] DIVU   = 6'h1B;

    typedef enum logic [1:0] {ImmZero, ImmSign, ImmUpper} imm_kind_e;

    function automatic imm_kind_e imm_kind(input logic [5:0] op);
        imm_kind_e kind;
        case (op)
            BEQ, BNE, LW, SW, ADDI, ADDIU, SLTI, SLTIU: kind = ImmSign;
            LUI:                                        kind = ImmUpper;
            default:                                    kind = ImmZero;
        endcase
        return kind;
    endfunction

endpackage

// File: rtl/id_stage_pipe_if.sv
// IF->ID, WB->ID and ID->EX signal bundle; master drives instructions/WB, slave is the ID stage.
interface id_stage_pipe_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned RADR_W = 5
);
    logic              in_valid;
    logic              in_ready;
    logic [31:0]       in_ins;
    logic [31:0]       in_pc;
    logic              flush;
    logic              wb_we;
    logic [RADR_W-1:0] wb_adr;
    logic [DATA_W-1:0] wb_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_rdata1;
    logic [DATA_W-1:0] out_rdata2;
    logic [DATA_W-1:0] out_imm;
    logic [RADR_W-1:0] out_wadr;
    logic              out_we;
    logic              out_is_load;
    logic [5:0]        out_op;
    logic [5:0]        out_func;
    logic [31:0]       out_pc;
    logic [15:0]       stall_cnt;

    modport master (
        output in_valid, in_ins, in_pc, flush, wb_we, wb_adr, wb_data, out_ready,
        input  in_ready, out_valid, out_rdata1, out_rdata2, out_imm, out_wadr, out_we,
        input  out_is_load, out_op, out_func, out_pc, stall_cnt
    );

    modport slave (
        input  in_valid, in_ins, in_pc, flush, wb_we, wb_adr, wb_data, out_ready,
        output in_ready, out_valid, out_rdata1, out_rdata2, out_imm, out_wadr, out_we,
        output out_is_load, out_op, out_func, out_pc, stall_cnt
    );
endinterface

// File: rtl/id_stage_pipe_regfile_2r1w.sv
// 2-read/1-write register file with synchronous clear and optional same-cycle write-through.
module id_stage_pipe_regfile_2r1w #(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned RADR_W    = 5,
    parameter bit          ZERO_REG  = 1'b1,
    parameter bit          BYPASS_EN = 1'b1
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              we,
    input  logic [RADR_W-1:0] wadr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [RADR_W-1:0] radr1,
    input  logic [RADR_W-1:0] radr2,
    output logic [DATA_W-1:0] rdata1,
    output logic [DATA_W-1:0] rdata2
);
    localparam int unsigned REG_COUNT = 2 ** RADR_W;

    logic [DATA_W-1:0] mem [REG_COUNT];
    logic              wr_en;

    assign wr_en = we && !(ZERO_REG && wadr == '0);

    always_ff @(posedge CLK) begin
        if (!RST) begin
            for (int i = 0; i < REG_COUNT; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en) begin
            mem[wadr] <= wdata;
        end
    end

    always_comb begin
        rdata1 = mem[radr1];
        if (BYPASS_EN && we && wadr == radr1 && radr1 != '0) rdata1 = wdata;
        if (ZERO_REG && radr1 == '0) rdata1 = '0;
    end

    always_comb begin
        rdata2 = mem[radr2];
        if (BYPASS_EN && we && wadr == radr2 && radr2 != '0) rdata2 = wdata;
        if (ZERO_REG && radr2 == '0) rdata2 = '0;
    end

endmodule

// File: rtl/id_stage_pipe.sv
// MIPS instruction-decode stage: regfile read, field decode, load-use hazard and ID/EX register.
module id_stage_pipe
    import id_stage_pipe_pkg::*;
#(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned RADR_W    = 5,
    parameter bit          ZERO_REG  = 1'b1,
    parameter bit          BYPASS_EN = 1'b1
) (
    input logic            CLK,
    input logic            RST,
    id_stage_pipe_if.slave bus
);
    typedef struct packed {
        logic              valid;
        logic [DATA_W-1:0] rdata1;
        logic [DATA_W-1:0] rdata2;
        logic [DATA_W-1:0] imm;
        logic [RADR_W-1:0] wadr;
        logic              we;
        logic              is_load;
        logic [5:0]        op;
        logic [5:0]        func;
        logic [31:0]       pc;
    } idex_t;

    idex_t             idex_q, idex_d;
    logic [15:0]       stall_cnt_q, stall_cnt_d;

    logic [31:0]       ins;
    logic [5:0]        op, func;
    logic [RADR_W-1:0] rs, rt, rd, wadr;
    logic              we, uses_rt, stall, in_ready;
    logic [DATA_W-1:0] imm, rf_rdata1, rf_rdata2;

    assign ins  = bus.in_ins;
    assign op   = ins[31:26];
    assign func = ins[5:0];
    assign rs   = RADR_W'(ins[25:21]);
    assign rt   = RADR_W'(ins[20:16]);
    assign rd   = RADR_W'(ins[15:11]);

    id_stage_pipe_regfile_2r1w #(
        .DATA_W   (DATA_W),
        .RADR_W   (RADR_W),
        .ZERO_REG (ZERO_REG),
        .BYPASS_EN(BYPASS_EN)
    ) u_regfile (
        .CLK   (CLK),
        .RST   (RST),
        .we    (bus.wb_we),
        .wadr  (bus.wb_adr),
        .wdata (bus.wb_data),
        .radr1 (rs),
        .radr2 (rt),
        .rdata1(rf_rdata1),
        .rdata2(rf_rdata2)
    );

    // JALR is an R_FORM funct, so it takes rd through the R_FORM branch.
    always_comb begin
        if (op == JAL) begin
            wadr = RADR_W'(5'd31);
        end else if (op == R_FORM) begin
            wadr = rd;
        end else begin
            wadr = rt;
        end
    end

    always_comb begin
        we = 1'b0;
        case (op)
            R_FORM:  we = !(func inside {JR, MTHI, MTLO, MULT, MULTU, DIV, DIVU});
            LW, JAL: we = 1'b1;
            default: we = (op[5:3] == 3'b001);
        endcase
        if (ZERO_REG && wadr == '0) we = 1'b0;
    end

    // LUI result is a 32-bit value that is then sign-extended to the datapath width.
    always_comb begin
        case (imm_kind(op))
            ImmSign:  imm = {{(DATA_W-16){ins[15]}}, ins[15:0]};
            ImmUpper: imm = {{(DATA_W-31){ins[15]}}, ins[14:0], 16'h0000};
            default:  imm = {{(DATA_W-16){1'b0}}, ins[15:0]};
        endcase
    end

    assign uses_rt  = op inside {R_FORM, BEQ, BNE, SW};
    assign stall    = idex_q.valid && idex_q.is_load && idex_q.wadr != '0 && bus.in_valid &&
                      (idex_q.wadr == rs || (uses_rt && idex_q.wadr == rt));
    assign in_ready = !bus.flush && !stall && (!idex_q.valid || bus.out_ready);

    always_comb begin
        idex_d = idex_q;
        if (bus.flush) begin
            idex_d.valid = 1'b0;
        end else if (bus.in_valid && in_ready) begin
            idex_d.valid   = 1'b1;
            idex_d.rdata1  = rf_rdata1;
            idex_d.rdata2  = rf_rdata2;
            idex_d.imm     = imm;
            idex_d.wadr    = wadr;
            idex_d.we      = we;
            idex_d.is_load = (op == LW);
            idex_d.op      = op;
            idex_d.func    = func;
            idex_d.pc      = bus.in_pc;
        end else if (bus.out_ready) begin
            idex_d.valid = 1'b0;
        end

        stall_cnt_d = stall_cnt_q;
        if (stall && !bus.flush && stall_cnt_q != 16'hFFFF) stall_cnt_d = stall_cnt_q + 16'd1;
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            idex_q      <= '0;
            stall_cnt_q <= '0;
        end else begin
            idex_q      <= idex_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign bus.in_ready    = in_ready;
    assign bus.out_valid   = idex_q.valid;
    assign bus.out_rdata1  = idex_q.rdata1;
    assign bus.out_rdata2  = idex_q.rdata2;
    assign bus.out_imm     = idex_q.imm;
    assign bus.out_wadr    = idex_q.wadr;
    assign bus.out_we      = idex_q.we;
    assign bus.out_is_load = idex_q.is_load;
    assign bus.out_op      = idex_q.op;
    assign bus.out_func    = idex_q.func;
    assign bus.out_pc      = idex_q.pc;
    assign bus.stall_cnt   = stall_cnt_q;

endmodule

// File: tb/tb_id_stage_pipe.sv
// Bench for id_stage_pipe: directed literal checks plus randomized traffic against a behavioural model.
module tb_id_stage_pipe;

    logic CLK = 1'b0;
    logic RST = 1'b0;
    logic chk_en = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;
    logic [31:0] pc_ctr = 32'h0000_1000;

    always #5 CLK = ~CLK;

    id_stage_pipe_if #(.DATA_W(32), .RADR_W(5)) bus ();

    id_stage_pipe #(
        .DATA_W   (32),
        .RADR_W   (5),
        .ZERO_REG (1'b1),
        .BYPASS_EN(1'b1)
    ) dut (
        .CLK(CLK),
        .RST(RST),
        .bus(bus)
    );

    // Behavioural model state: architectural registers plus the ID/EX contents.
    logic [31:0] m_regs [32];
    logic        m_valid, m_we, m_load;
    logic [31:0] m_rd1, m_rd2, m_imm, m_pc;
    logic [4:0]  m_wadr;
    logic [5:0]  m_op, m_func;
    int          m_cnt;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
        end
    endtask

    function automatic logic [31:0] f_imm(input logic [31:0] ins);
        logic [5:0] op;
        op = ins[31:26];
        if (op == 6'h0F) return {ins[15:0], 16'h0000};
        if (op inside {6'h04, 6'h05, 6'h23, 6'h2B, 6'h08, 6'h09, 6'h0A, 6'h0B})
            return {{16{ins[15]}}, ins[15:0]};
        return {16'h0000, ins[15:0]};
    endfunction

    function automatic logic [4:0] f_wadr(input logic [31:0] ins);
        if (ins[31:26] == 6'h03) return 5'd31;
        if (ins[31:26] == 6'h00) return ins[15:11];
        return ins[20:16];
    endfunction

    function automatic logic f_we(input logic [31:0] ins);
        logic [5:0] op;
        logic       w;
        op = ins[31:26];
        if (op == 6'h00)
            w = !(ins[5:0] inside {6'h08, 6'h11, 6'h13, 6'h18, 6'h19, 6'h1A, 6'h1B});
        else if (op == 6'h03 || op == 6'h23)
            w = 1'b1;
        else
            w = (op >= 6'h08 && op <= 6'h0F);
        return w && (f_wadr(ins) != 5'd0);
    endfunction

    function automatic logic [31:0] f_read(input logic [4:0] r);
        if (r == 5'd0) return 32'h0;
        if (bus.wb_we && bus.wb_adr == r) return bus.wb_data;
        return m_regs[r];
    endfunction

    function automatic logic m_stall();
        logic [31:0] ins;
        logic        urt;
        ins = bus.in_ins;
        urt = ins[31:26] inside {6'h00, 6'h04, 6'h05, 6'h2B};
        return m_valid && m_load && m_wadr != 5'd0 && bus.in_valid &&
               (m_wadr == ins[25:21] || (urt && m_wadr == ins[20:16]));
    endfunction

    function automatic logic m_ready();
        return !bus.flush && !m_stall() && (!m_valid || bus.out_ready);
    endfunction

    always @(posedge CLK) begin : model
        logic        st, rdy;
        logic [31:0] rd1, rd2;
        if (!RST) begin
            for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
            m_valid = 0; m_we = 0; m_load = 0; m_rd1 = 0; m_rd2 = 0; m_imm = 0;
            m_pc = 0; m_wadr = 0; m_op = 0; m_func = 0; m_cnt = 0;
        end else begin
            st  = m_stall();
            rdy = m_ready();
            rd1 = f_read(bus.in_ins[25:21]);
            rd2 = f_read(bus.in_ins[20:16]);
            if (bus.flush) begin
                m_valid = 1'b0;
            end else if (bus.in_valid && rdy) begin
                m_valid = 1'b1;
                m_rd1   = rd1;
                m_rd2   = rd2;
                m_imm   = f_imm(bus.in_ins);
                m_wadr  = f_wadr(bus.in_ins);
                m_we    = f_we(bus.in_ins);
                m_load  = (bus.in_ins[31:26] == 6'h23);
                m_op    = bus.in_ins[31:26];
                m_func  = bus.in_ins[5:0];
                m_pc    = bus.in_pc;
            end else if (bus.out_ready) begin
                m_valid = 1'b0;
            end
            if (st && !bus.flush && m_cnt < 65535) m_cnt++;
            if (bus.wb_we && bus.wb_adr != 5'd0) m_regs[bus.wb_adr] = bus.wb_data;
        end
    end

    always @(negedge CLK) begin : compare
        if (chk_en) begin
            chk("out_valid", bus.out_valid, m_valid);
            chk("in_ready", bus.in_ready, m_ready());
            chk("stall_cnt", bus.stall_cnt, m_cnt);
            chk("out_rdata1", bus.out_rdata1, m_rd1);
            chk("out_rdata2", bus.out_rdata2, m_rd2);
            chk("out_imm", bus.out_imm, m_imm);
            chk("out_wadr", bus.out_wadr, m_wadr);
            chk("out_we", bus.out_we, m_we);
            chk("out_is_load", bus.out_is_load, m_load);
            chk("out_op", bus.out_op, m_op);
            chk("out_func", bus.out_func, m_func);
            chk("out_pc", bus.out_pc, m_pc);
        end
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] ins, input logic ordy, input logic fl);
        bus.in_valid  = v;
        bus.in_ins    = ins;
        bus.in_pc     = pc_ctr;
        bus.out_ready = ordy;
        bus.flush     = fl;
        pc_ctr        = pc_ctr + 32'd4;
    endtask

    task automatic wb(input logic we, input logic [4:0] a, input logic [31:0] d);
        bus.wb_we   = we;
        bus.wb_adr  = a;
        bus.wb_data = d;
    endtask

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        logic [5:0] ops [16];
        logic [5:0] fns [8];
        logic [5:0] op, fn;
        logic [31:0] ins;
        ops = '{6'h00, 6'h00, 6'h00, 6'h03, 6'h04, 6'h05, 6'h08, 6'h09,
                6'h0C, 6'h0D, 6'h0F, 6'h23, 6'h23, 6'h2B, 6'h02, 6'h0E};
        fns = '{6'h20, 6'h21, 6'h08, 6'h09, 6'h11, 6'h18, 6'h1B, 6'h2A};

        drive(1'b0, 32'h0, 1'b1, 1'b0);
        wb(1'b0, 5'd0, 32'h0);
        step();
        step();
        chk_en = 1'b1;
        chk("rst_out_valid", bus.out_valid, 1'b0);
        chk("rst_stall_cnt", bus.stall_cnt, 16'h0);
        chk("rst_out_imm", bus.out_imm, 32'h0);
        RST = 1'b1;

        // ADDI r1,r0,-1
        drive(1'b1, 32'h2001FFFF, 1'b1, 1'b0);
        step();
        chk("addi_valid", bus.out_valid, 1'b1);
        chk("addi_imm", bus.out_imm, 32'hFFFFFFFF);
        chk("addi_wadr", bus.out_wadr, 5'd1);
        chk("addi_we", bus.out_we, 1'b1);
        drive(1'b1, 32'h34028000, 1'b1, 1'b0);
        step();
        chk("ori_imm", bus.out_imm, 32'h00008000);
        drive(1'b1, 32'h3C031234, 1'b1, 1'b0);
        step();
        chk("lui_imm", bus.out_imm, 32'h12340000);
        drive(1'b1, 32'h0C000010, 1'b1, 1'b0);
        step();
        chk("jal_wadr", bus.out_wadr, 5'd31);
        chk("jal_we", bus.out_we, 1'b1);

        // Write-through of r5 into a same-cycle ADD r6,r5,r0; writes to r0 are dropped.
        wb(1'b1, 5'd5, 32'hDEADBEEF);
        drive(1'b1, 32'h00A03020, 1'b1, 1'b0);
        step();
        chk("bypass_rdata1", bus.out_rdata1, 32'hDEADBEEF);
        wb(1'b1, 5'd0, 32'd7);
        drive(1'b1, 32'h00003020, 1'b1, 1'b0);
        step();
        chk("r0_bypass", bus.out_rdata1, 32'h0);
        wb(1'b0, 5'd0, 32'h0);
        drive(1'b1, 32'h00003020, 1'b1, 1'b0);
        step();
        chk("r0_stored", bus.out_rdata1, 32'h0);

        // LW r4,0(r0) then ADD r7,r4,r4: one bubble.
        drive(1'b1, 32'h8C040000, 1'b1, 1'b0);
        step();
        chk("lw_is_load", bus.out_is_load, 1'b1);
        drive(1'b1, 32'h00843820, 1'b1, 1'b0);
        #1;
        chk("lu_in_ready", bus.in_ready, 1'b0);
        step();
        chk("lu_bubble", bus.out_valid, 1'b0);
        chk("lu_stall_cnt", bus.stall_cnt, 16'd1);
        #1;
        chk("lu_in_ready_after", bus.in_ready, 1'b1);
        step();
        chk("lu_add_valid", bus.out_valid, 1'b1);
        chk("lu_add_wadr", bus.out_wadr, 5'd7);
        chk("lu_add_func", bus.out_func, 6'h20);

        // Backpressure then flush.
        drive(1'b1, 32'h2001FFFF, 1'b1, 1'b0);
        step();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'h34028000, 1'b0, 1'b0);
            #1;
            chk("bp_in_ready", bus.in_ready, 1'b0);
            step();
            chk("bp_valid", bus.out_valid, 1'b1);
            chk("bp_imm", bus.out_imm, 32'hFFFFFFFF);
        end
        drive(1'b1, 32'h3C031234, 1'b1, 1'b1);
        step();
        chk("flush_valid", bus.out_valid, 1'b0);
        chk("flush_no_capture", bus.out_imm, 32'hFFFFFFFF);

        // Fill registers, hold a valid entry, then reset mid-operation.
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        for (int i = 1; i < 32; i++) begin
            wb(1'b1, 5'(i), 32'hA5A5_0000 | 32'(i));
            step();
        end
        wb(1'b0, 5'd0, 32'h0);
        drive(1'b1, 32'h8C040000, 1'b1, 1'b0);
        step();
        drive(1'b1, 32'h00843820, 1'b1, 1'b0);
        step();
        chk("pre_rst_cnt", bus.stall_cnt, 16'd2);
        drive(1'b0, 32'h2001FFFF, 1'b0, 1'b0);
        step();
        RST = 1'b0;
        step();
        RST = 1'b1;
        chk("mid_rst_valid", bus.out_valid, 1'b0);
        chk("mid_rst_cnt", bus.stall_cnt, 16'h0);
        for (int i = 1; i < 32; i++) begin
            drive(1'b1, (32'(i) << 21) | (32'(i) << 16) | 32'h20, 1'b1, 1'b0);
            step();
            chk("rst_read1", bus.out_rdata1, 32'h0);
            chk("rst_read2", bus.out_rdata2, 32'h0);
        end

        // Randomized traffic, small register window to provoke hazards and bypasses.
        for (int c = 0; c < 3000; c++) begin
            op  = ops[$urandom_range(0, 15)];
            fn  = (op == 6'h00) ? fns[$urandom_range(0, 7)] : 6'($urandom);
            ins = {op, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                   5'($urandom_range(0, 7)), 5'($urandom), fn};
            drive($urandom_range(0, 3) != 0, ins, $urandom_range(0, 9) < 7,
                  $urandom_range(0, 19) == 0);
            wb($urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)), $urandom);
            RST = ($urandom_range(0, 199) != 0);
            step();
        end
        RST = 1'b1;
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        wb(1'b0, 5'd0, 32'h0);
        step();
        step();
        chk_en = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
